arbitro_escrita_reg: RTL and testbench
======================================

Name: arbitro_escrita_reg

Overview:
- Shares the register bank's single write port between two producers: requester 0 (ALU writeback) and requester 1 (load/multi-cycle unit).
- Uses round-robin arbitration with a valid/ready handshake.
- Keeps a busy scoreboard of registers with a pending write and flags read hazards for the decode stage.
- Sits between the producers and the register bank's RegWrite/writeReg/writeData inputs.

Parameters:
- N_REG, 32, number of architectural registers.
- ADDR_W, 5, register address width, log2(N_REG).
- DATA_W, 32, write data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_reg  in  ADDR_W  destination register of requester 0.
- req0_data  in  DATA_W  write data of requester 0.
- req0_ready  out  1  requester 0 granted this cycle; combinational.
- req1_valid  in  1  requester 1 has a write pending.
- req1_reg  in  ADDR_W  destination register of requester 1.
- req1_data  in  DATA_W  write data of requester 1.
- req1_ready  out  1  requester 1 granted this cycle; combinational.
- reserve_valid  in  1  issue stage reserves a destination register.
- reserve_reg  in  ADDR_W  register being reserved.
- chk_reg1  in  ADDR_W  first source register checked for hazard.
- chk_reg2  in  ADDR_W  second source register checked for hazard.
- hazard1  out  1  chk_reg1 has a pending write; combinational.
- hazard2  out  1  chk_reg2 has a pending write; combinational.
- RegWrite  out  1  write enable to the register bank; registered.
- writeReg  out  ADDR_W  write address to the register bank; registered.
- writeData  out  DATA_W  write data to the register bank; registered.
- busy_vec  out  N_REG  scoreboard contents; bit i = register i pending.
- err_unreserved  out  1  sticky flag: a write arrived for a register that was not reserved.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - RegWrite, writeReg, writeData, busy_vec and err_unreserved all go to 0.
  - last_grant=1, so requester 0 wins the first conflict.
  - Any in-flight transfer is dropped; ready outputs are 0 while in reset.
- Arbitration (combinational):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not in last_grant gets ready=1.
  - Neither valid: both ready=0.
  - At most one ready is ever high.
- Handshake:
  - A transfer completes on a posedge where valid&ready.
  - The requester must hold reg/data stable while valid=1 and ready=0; valid may not drop before the transfer.
  - last_grant updates to the winner only on a transfer.
- Output stage, 1-cycle latency:
  - On a transfer edge, writeReg/writeData are loaded from the winner and RegWrite=1, except when the destination is 0: then RegWrite=0 (the transfer still completes).
  - With no transfer, RegWrite=0 and writeReg/writeData hold their previous values.
  - The register bank writes on the following edge, so a value is readable two edges after the handshake.
- Scoreboard:
  - reserve_valid with reserve_reg≠0 sets busy[reserve_reg] on the edge.
  - An edge with RegWrite=1 clears busy[writeReg].
  - Reserve and clear of the same register on the same edge: reserve wins and the bit stays 1.
  - Register 0 is never busy.
- Hazards:
  - hazardN = busy[chk_regN].
  - Because the busy bit clears on the same edge the bank writes, no stale read is possible.
  - hazardN is always 0 when chk_regN=0.
- Error:
  - A transfer to a nonzero register whose busy bit is 0 and is not being reserved that cycle sets err_unreserved.
  - err_unreserved is cleared only by reset; the write still proceeds.
- Back-to-back: one transfer per cycle is sustained; with both requesters valid continuously, grants alternate 0,1,0,1.

Decomposition:
- Package arbitro_pkg holds N_REG, ADDR_W and DATA_W as localparams, plus the REG_ZERO constant.
- One sub-module, placar_registradores, implements the busy vector: set/clear ports, reserve-wins priority, two combinational lookup ports.
- Arbitration, the output register and the error flag stay in the top module.

Test Plan:
- Reset: with busy bits set and a transfer pending, drop rst_n mid-cycle → all outputs 0 immediately; first post-reset conflict grants requester 0.
- Single write: reserve r5, then req0 writes r5=0xDEADBEEF → req0_ready=1. Next cycle RegWrite=1, writeReg=5, writeData=0xDEADBEEF. hazard1 (chk_reg1=5) is 1 until that edge, then 0. busy_vec[5]=0 afterwards.
- Contention: both valid for 4 cycles, r3=0x11 from req0 and r4=0x22 from req1 → grants 0,1,0,1. The losing requester holds stable, and writeReg sequence is 3,4,3,4.
- Register 0: reserve r0 and write r0=0xFFFF via req1 → handshake completes, RegWrite stays 0, busy_vec stays 0, hazard with chk_reg=0 is 0, err_unreserved stays 0.
- Simultaneous reserve/clear: r7 busy, its write is in the output stage and reserve_valid for r7 arrives on the same edge → busy_vec[7] remains 1 and hazard2 (chk_reg2=7) remains 1.
- Unreserved write: req0 writes r9 with busy[9]=0 → err_unreserved=1 on the next cycle and stays 1. The write still appears with writeReg=9.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared sizes for the register-bank write arbiter and its busy scoreboard.
package arbitro_pkg;

    localparam int N_REG  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/placar_registradores.sv
// Busy scoreboard: one bit per register with a write still in flight.
module placar_registradores
    import arbitro_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              setEn,
    input  logic [ADDR_W-1:0] setReg,
    input  logic              clrEn,
    input  logic [ADDR_W-1:0] clrReg,
    input  logic [ADDR_W-1:0] lookReg1,
    input  logic [ADDR_W-1:0] lookReg2,
    output logic              look1,
    output logic              look2,
    output logic [N_REG-1:0]  busy
);

    logic [N_REG-1:0] busyQ;
    logic [N_REG-1:0] busyNxt;

    // Set is applied after clear so a same-edge reserve keeps the bit high.
    always_comb begin
        busyNxt = busyQ;
        for (int i = 0; i < N_REG; i++) begin
            if (clrEn && (clrReg == ADDR_W'(i)))
                busyNxt[i] = 1'b0;
            if (setEn && (setReg == ADDR_W'(i)))
                busyNxt[i] = 1'b1;
        end
        busyNxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busyQ <= '0;
        else
            busyQ <= busyNxt;
    end

    assign look1 = busyQ[lookReg1];
    assign look2 = busyQ[lookReg2];
    assign busy  = busyQ;

endmodule

// File: rtl/arbitro_escrita_reg.sv
// Round-robin arbiter sharing the register bank's write port between two
// producers, with a registered write stage and read-hazard scoreboard.
module arbitro_escrita_reg
    import arbitro_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              reserve_valid,
    input  logic [ADDR_W-1:0] reserve_reg,
    input  logic [ADDR_W-1:0] chk_reg1,
    input  logic [ADDR_W-1:0] chk_reg2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic [N_REG-1:0]  busy_vec,
    output logic              err_unreserved
);

    logic              lastGrant;
    logic              grant0;
    logic              grant1;
    logic              xfer;
    logic [ADDR_W-1:0] winReg;
    logic [DATA_W-1:0] winData;
    logic              reserveSet;
    logic              winBusy;
    logic              unreserved;

    // lastGrant=1 means requester 1 won last, so requester 0 has priority.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            grant0 = req0_valid && (!req1_valid || lastGrant);
            grant1 = req1_valid && (!req0_valid || !lastGrant);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 || grant1;
    assign winReg     = grant1 ? req1_reg  : req0_reg;
    assign winData    = grant1 ? req1_data : req0_data;
    assign reserveSet = reserve_valid && (reserve_reg != REG_ZERO);
    assign winBusy    = busy_vec[winReg];
    assign unreserved = xfer && (winReg != REG_ZERO) && !winBusy &&
                        !(reserveSet && (reserve_reg == winReg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lastGrant <= 1'b1;
        else if (xfer)
            lastGrant <= grant1;
    end

    // Write stage: one cycle between handshake and the bank's write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            RegWrite <= xfer && (winReg != REG_ZERO);
            if (xfer) begin
                writeReg  <= winReg;
                writeData <= winData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_unreserved <= 1'b0;
        else if (unreserved)
            err_unreserved <= 1'b1;
    end

    placar_registradores uPlacar (
        .clk      (clk),
        .rst_n    (rst_n),
        .setEn    (reserveSet),
        .setReg   (reserve_reg),
        .clrEn    (RegWrite),
        .clrReg   (writeReg),
        .lookReg1 (chk_reg1),
        .lookReg2 (chk_reg2),
        .look1    (hazard1),
        .look2    (hazard2),
        .busy     (busy_vec)
    );

endmodule

// File: tb/tb_arbitro_escrita_reg.sv
// Scoreboard bench for arbitro_escrita_reg: a cycle model predicts grants,
// hazards and the next write-stage contents, which are queued and compared.
module tb_arbitro_escrita_reg;
    import arbitro_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid, reserve_valid;
    logic [ADDR_W-1:0] req0_reg, req1_reg, reserve_reg, chk_reg1, chk_reg2;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready, hazard1, hazard2;
    logic              RegWrite, err_unreserved;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [N_REG-1:0]  busy_vec;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } saida_t;

    saida_t fila[$];

    logic [N_REG-1:0]  mBusy;
    logic              mLast, mErr, mWe;
    logic [ADDR_W-1:0] mWReg;
    logic [DATA_W-1:0] mWData;

    int nCmp = 0;
    int nErr = 0;

    arbitro_escrita_reg dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .reserve_valid(reserve_valid), .reserve_reg(reserve_reg),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .hazard1(hazard1), .hazard2(hazard2),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .busy_vec(busy_vec), .err_unreserved(err_unreserved)
    );

    always #5 clk = ~clk;

    task automatic confere(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modeloReset();
        mBusy = '0; mLast = 1'b1; mErr = 1'b0;
        mWe = 1'b0; mWReg = '0; mWData = '0;
        fila.delete();
    endtask

    task automatic quieto();
        req0_valid = 0; req1_valid = 0; reserve_valid = 0;
    endtask

    // One clock: check combinational outputs mid-cycle, predict the edge,
    // then compare the write stage just after the edge.
    task automatic ciclo();
        logic g0, g1, xf;
        logic [ADDR_W-1:0] wr;
        logic [DATA_W-1:0] wd;
        logic [N_REG-1:0]  nb;
        saida_t e;
        @(negedge clk);
        g0 = req0_valid && (!req1_valid || mLast);
        g1 = req1_valid && (!req0_valid || !mLast);
        confere("req0_ready", req0_ready, g0);
        confere("req1_ready", req1_ready, g1);
        confere("hazard1", hazard1, (chk_reg1 != 0) && mBusy[chk_reg1]);
        confere("hazard2", hazard2, (chk_reg2 != 0) && mBusy[chk_reg2]);
        confere("busy_vec", busy_vec, mBusy);
        confere("err", err_unreserved, mErr);
        xf = g0 || g1;
        wr = g1 ? req1_reg : req0_reg;
        wd = g1 ? req1_data : req0_data;
        nb = mBusy;
        if (mWe) nb[mWReg] = 1'b0;
        if (reserve_valid && reserve_reg != 0) nb[reserve_reg] = 1'b1;
        if (xf && wr != 0 && !mBusy[wr] && !(reserve_valid && reserve_reg == wr)) mErr = 1'b1;
        if (xf) begin mWReg = wr; mWData = wd; mLast = g1; end
        mWe = xf && (wr != 0);
        mBusy = nb;
        e.we = mWe; e.r = mWReg; e.d = mWData;
        fila.push_back(e);
        @(posedge clk); #1;
        e = fila.pop_front();
        confere("RegWrite", RegWrite, e.we);
        confere("writeReg", writeReg, e.r);
        confere("writeData", writeData, e.d);
        confere("busy_post", busy_vec, mBusy);
        confere("err_post", err_unreserved, mErr);
    endtask

    initial begin
        logic [ADDR_W-1:0] seq [4];
        logic              rv  [4];
        logic [ADDR_W-1:0] rr  [4];
        seq = '{5'd3, 5'd4, 5'd3, 5'd4};
        rv  = '{1'b0, 1'b1, 1'b1, 1'b0};
        rr  = '{5'd0, 5'd3, 5'd4, 5'd0};

        rst_n = 0; quieto();
        req0_reg = 0; req1_reg = 0; reserve_reg = 0; chk_reg1 = 0; chk_reg2 = 0;
        req0_data = 0; req1_data = 0;
        modeloReset();
        #1;
        confere("rst_RegWrite", RegWrite, 0);
        confere("rst_writeReg", writeReg, 0);
        confere("rst_writeData", writeData, 0);
        confere("rst_busy", busy_vec, 0);
        confere("rst_err", err_unreserved, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // single reserved write to r5
        reserve_valid = 1; reserve_reg = 5; chk_reg1 = 5;
        ciclo();
        reserve_valid = 0; req0_valid = 1; req0_reg = 5; req0_data = 32'hDEADBEEF;
        ciclo();
        confere("sw_we", RegWrite, 1);
        confere("sw_data", writeData, 32'hDEADBEEF);
        req0_valid = 0;
        ciclo();
        confere("sw_busy5", busy_vec[5], 0);
        ciclo();

        // register 0 write via requester 1
        reserve_valid = 1; reserve_reg = 0; chk_reg1 = 0; chk_reg2 = 0;
        req1_valid = 1; req1_reg = 0; req1_data = 32'hFFFF;
        ciclo();
        confere("r0_we", RegWrite, 0);
        quieto();
        ciclo();
        confere("r0_busy", busy_vec, 0);

        // reserve and clear of r7 on the same edge
        reserve_valid = 1; reserve_reg = 7; chk_reg2 = 7;
        ciclo();
        reserve_valid = 0; req1_valid = 1; req1_reg = 7; req1_data = 32'h77;
        ciclo();
        req1_valid = 0; reserve_valid = 1; reserve_reg = 7;
        ciclo();
        confere("rc_busy7", busy_vec[7], 1);
        reserve_valid = 0;
        ciclo();
        confere("rc_hazard2", hazard2, 1);

        // contention: grants alternate 0,1,0,1
        reserve_valid = 1; reserve_reg = 3; ciclo();
        reserve_reg = 4; ciclo();
        reserve_valid = 0;
        req0_valid = 1; req0_reg = 3; req0_data = 32'h11;
        req1_valid = 1; req1_reg = 4; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            reserve_valid = rv[i]; reserve_reg = rr[i];
            ciclo();
            confere("ct_seq", writeReg, seq[i]);
        end
        quieto();
        ciclo(); ciclo();

        // unreserved write to r9
        req0_valid = 1; req0_reg = 9; req0_data = 32'h99;
        ciclo();
        confere("ur_reg", writeReg, 9);
        confere("ur_err", err_unreserved, 1);
        quieto();
        ciclo(); ciclo();
        confere("ur_sticky", err_unreserved, 1);

        // asynchronous reset mid-cycle with busy bits and a pending transfer
        reserve_valid = 1; reserve_reg = 10; ciclo();
        reserve_reg = 11; ciclo();
        reserve_valid = 0; req0_valid = 1; req0_reg = 10; req0_data = 32'hAAAA;
        @(negedge clk); #2 rst_n = 0; #1;
        confere("ar_RegWrite", RegWrite, 0);
        confere("ar_writeReg", writeReg, 0);
        confere("ar_writeData", writeData, 0);
        confere("ar_busy", busy_vec, 0);
        confere("ar_err", err_unreserved, 0);
        confere("ar_ready0", req0_ready, 0);
        confere("ar_ready1", req1_ready, 0);
        @(posedge clk); #1 rst_n = 1;
        modeloReset();

        // first conflict after reset goes to requester 0
        req0_valid = 1; req0_reg = 12; req0_data = 32'h1212;
        req1_valid = 1; req1_reg = 13; req1_data = 32'h1313;
        ciclo();
        confere("pr_first", writeReg, 12);
        ciclo();
        confere("pr_second", writeReg, 13);
        quieto();
        ciclo();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
